// File: rtl/val2_seq_pkg.sv
// Shared types and constants for the Val2 shift sequencer.
package val2_seq_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int MAX_SHIFT = 31;
  localparam int AMT_W     = $clog2(MAX_SHIFT + 1);

endpackage

// File: rtl/val2_shift_step.sv
// One combinational shift step of k bits (k = 0..8).
// Carry-out logic exists only when VAL2_SEQ_CARRY_EN is defined.
module val2_shift_step
  import val2_seq_pkg::*;
(
  input  logic [31:0] data,
  input  shift_t      sh_type,
  input  logic [3:0]  k,
  output logic [31:0] result
`ifdef VAL2_SEQ_CARRY_EN
  ,
  output logic        carry_out
`endif
);

  logic [5:0] amt;
  assign amt = {2'b00, k};

  always_comb begin
    case (sh_type)
      LSL:     result = data << amt;
      LSR:     result = data >> amt;
      ASR:     result = 32'($signed(data) >>> amt);
      default: result = (data >> amt) | (data << (6'd32 - amt));
    endcase
  end

`ifdef VAL2_SEQ_CARRY_EN
  logic [4:0] lsl_idx;
  logic [4:0] rsh_idx;
  assign lsl_idx = 5'(6'd32 - amt);
  assign rsh_idx = 5'(amt - 6'd1);

  // Right shifts and rotates all lose bit k-1 last; LSL loses bit 32-k.
  always_comb begin
    if (k == 4'd0)
      carry_out = 1'b0;
    else if (sh_type == LSL)
      carry_out = data[lsl_idx];
    else
      carry_out = data[rsh_idx];
  end
`endif

endmodule

// File: rtl/val2_shift_sequencer.sv
// Iterative Val2 generator: shifts STEP bits per cycle with ready/valid handshakes.
// Optional carry output enabled by defining VAL2_SEQ_CARRY_EN.
module val2_shift_sequencer
  import val2_seq_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm,
  input  logic        for_mem,
  input  logic [11:0] shifter_operand,
  input  logic [31:0] val_rm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef VAL2_SEQ_CARRY_EN
  input  logic        carry_in,
  output logic        shifter_carry,
`endif
  output logic [31:0] val2_out
);

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_t             state_reg, state_next;
  logic [31:0]        data_reg, data_next;
  shift_t             type_reg, type_next;
  logic [AMT_W-1:0]   remaining_reg, remaining_next;
  logic               out_valid_reg, out_valid_next;
  logic [3:0]         k;
  logic [31:0]        step_data;
  logic               accept;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = out_valid_reg;
  assign val2_out  = data_reg;

  assign k = (remaining_reg >= STEP_AMT) ? 4'(STEP) : remaining_reg[3:0];

`ifdef VAL2_SEQ_CARRY_EN
  logic carry_reg, carry_next;
  logic step_carry;
  assign shifter_carry = carry_reg;
`endif

  val2_shift_step u_step (
    .data     (data_reg),
    .sh_type  (type_reg),
    .k        (k),
`ifdef VAL2_SEQ_CARRY_EN
    .carry_out(step_carry),
`endif
    .result   (step_data)
  );

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    type_next      = type_reg;
    remaining_next = remaining_reg;
`ifdef VAL2_SEQ_CARRY_EN
    carry_next     = carry_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (for_mem) begin
            data_next      = {20'b0, shifter_operand};
            type_next      = LSL;
            remaining_next = '0;
          end else if (imm) begin
            data_next      = {24'b0, shifter_operand[7:0]};
            type_next      = ROR;
            remaining_next = {shifter_operand[11:8], 1'b0};
          end else begin
            data_next      = val_rm;
            type_next      = shift_t'(shifter_operand[6:5]);
            remaining_next = shifter_operand[11:7];
          end
`ifdef VAL2_SEQ_CARRY_EN
          carry_next = carry_in;
`endif
          state_next = (remaining_next == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          data_next      = step_data;
          remaining_next = remaining_reg - AMT_W'(k);
`ifdef VAL2_SEQ_CARRY_EN
          if (k != 4'd0) carry_next = step_carry;
`endif
          if (remaining_next == '0) state_next = DONE;
        end
      end
      DONE: begin
        if (flush || (out_valid_reg && out_ready)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // out_valid trails DONE entry by one edge so every path sees a full result cycle first.
    out_valid_next = (state_reg == DONE) && (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      type_reg      <= LSL;
      remaining_reg <= '0;
      out_valid_reg <= 1'b0;
`ifdef VAL2_SEQ_CARRY_EN
      carry_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      type_reg      <= type_next;
      remaining_reg <= remaining_next;
      out_valid_reg <= out_valid_next;
`ifdef VAL2_SEQ_CARRY_EN
      carry_reg     <= carry_next;
`endif
    end
  end

endmodule
